// File: rtl/ps_astat_pkg.sv
// Shared constants for the arithmetic status / sticky register block.
package ps_astat_pkg;

    // ASTAT field positions
    localparam int AZ_BIT  = 0;
    localparam int AN_BIT  = 1;
    localparam int AV_BIT  = 2;
    localparam int AC_BIT  = 3;
    localparam int SV_BIT  = 4;
    localparam int SZ_BIT  = 5;

    // STKY field positions
    localparam int AVS_BIT = 0;
    localparam int SVS_BIT = 1;

    // Implemented widths; everything above reads as zero
    localparam int ASTAT_W = 6;
    localparam int STKY_W  = 2;

    localparam logic [15:0] ASTAT_MASK = 16'h003F;
    localparam logic [15:0] STKY_MASK  = 16'h0003;

    // Condition codes; bit 3 inverts the base condition
    localparam logic [3:0] COND_EQ    = 4'd0;
    localparam logic [3:0] COND_LT    = 4'd1;
    localparam logic [3:0] COND_LE    = 4'd2;
    localparam logic [3:0] COND_AC    = 4'd3;
    localparam logic [3:0] COND_AV    = 4'd4;
    localparam logic [3:0] COND_SV    = 4'd5;
    localparam logic [3:0] COND_SZ    = 4'd6;
    localparam logic [3:0] COND_TRUE  = 4'd7;
    localparam logic [3:0] COND_NE    = 4'd8;
    localparam logic [3:0] COND_GE    = 4'd9;
    localparam logic [3:0] COND_GT    = 4'd10;
    localparam logic [3:0] COND_NAC   = 4'd11;
    localparam logic [3:0] COND_NAV   = 4'd12;
    localparam logic [3:0] COND_NSV   = 4'd13;
    localparam logic [3:0] COND_NSZ   = 4'd14;
    localparam logic [3:0] COND_FALSE = 4'd15;

endpackage

// File: rtl/ps_astat_cond_eval.sv
// Combinational condition evaluation from registered ASTAT flags.
module ps_cond_eval
    import ps_astat_pkg::*;
(
    input  logic [ASTAT_W-1:0] astat,
    input  logic [3:0]         ps_cond,
    output logic               astat_ps_cond_true
);

    logic base;

    // Pick the base condition from the low three code bits, invert on bit 3
    always_comb begin
        base = 1'b0;
        case ({1'b0, ps_cond[2:0]})
            COND_EQ:   base = astat[AZ_BIT];
            COND_LT:   base = astat[AN_BIT];
            COND_LE:   base = astat[AN_BIT] | astat[AZ_BIT];
            COND_AC:   base = astat[AC_BIT];
            COND_AV:   base = astat[AV_BIT];
            COND_SV:   base = astat[SV_BIT];
            COND_SZ:   base = astat[SZ_BIT];
            COND_TRUE: base = 1'b1;
            default:   base = 1'b0;
        endcase
        astat_ps_cond_true = ps_cond[3] ? ~base : base;
    end

endmodule

// File: rtl/ps_astat.sv
// ASTAT / STKY register: captures shifter and ALU flags one cycle after
// issue, supports crossbar write/read and drives the condition result.
module ps_astat
    import ps_astat_pkg::*;
#(
    parameter int DATASIZE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ps_shf_en,
    input  logic                shf_ps_sv,
    input  logic                shf_ps_sz,
    input  logic                ps_alu_en,
    input  logic                alu_ps_az,
    input  logic                alu_ps_an,
    input  logic                alu_ps_av,
    input  logic                alu_ps_ac,
    input  logic                ps_astat_we,
    input  logic [DATASIZE-1:0] xb_dtx,
    input  logic                ps_stky_clr,
    input  logic                ps_astat_sel,
    output logic [DATASIZE-1:0] astat_xb_dt,
    input  logic [3:0]          ps_cond,
    output logic                astat_ps_cond_true
);

    logic                shf_en_d, alu_en_d;
    logic [ASTAT_W-1:0]  astat_q, astat_nxt;
    logic [STKY_W-1:0]   stky_q, stky_nxt;
    logic [DATASIZE-1:0] rd_nxt;
    logic                unused_xb_hi;

    // Only the implemented ASTAT bits of the write bus are consumed
    assign unused_xb_hi = ^xb_dtx[DATASIZE-1:ASTAT_W];

    // Next ASTAT/STKY: write data first, unit captures override per field
    always_comb begin
        astat_nxt = astat_q;
        if (ps_astat_we)
            astat_nxt = xb_dtx[ASTAT_W-1:0] & ASTAT_MASK[ASTAT_W-1:0];
        if (alu_en_d) begin
            astat_nxt[AZ_BIT] = alu_ps_az;
            astat_nxt[AN_BIT] = alu_ps_an;
            astat_nxt[AV_BIT] = alu_ps_av;
            astat_nxt[AC_BIT] = alu_ps_ac;
        end
        if (shf_en_d) begin
            astat_nxt[SV_BIT] = shf_ps_sv;
            astat_nxt[SZ_BIT] = shf_ps_sz;
        end

        // Clear first so a same-edge set survives
        stky_nxt = ps_stky_clr ? '0 : stky_q;
        if (alu_en_d && alu_ps_av) stky_nxt[AVS_BIT] = 1'b1;
        if (shf_en_d && shf_ps_sv) stky_nxt[SVS_BIT] = 1'b1;

        // Read mux uses pre-edge register contents, zero-extended
        rd_nxt = '0;
        if (ps_astat_sel) rd_nxt[STKY_W-1:0]  = stky_q & STKY_MASK[STKY_W-1:0];
        else              rd_nxt[ASTAT_W-1:0] = astat_q & ASTAT_MASK[ASTAT_W-1:0];
    end

    // Enable delays, status registers and registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shf_en_d    <= 1'b0;
            alu_en_d    <= 1'b0;
            astat_q     <= '0;
            stky_q      <= '0;
            astat_xb_dt <= '0;
        end else begin
            shf_en_d    <= ps_shf_en;
            alu_en_d    <= ps_alu_en;
            astat_q     <= astat_nxt;
            stky_q      <= stky_nxt;
            astat_xb_dt <= rd_nxt;
        end
    end

    ps_cond_eval u_cond (
        .astat              (astat_q),
        .ps_cond            (ps_cond),
        .astat_ps_cond_true (astat_ps_cond_true)
    );

endmodule

// File: tb/tb_ps_astat.sv
// Self-checking bench for ps_astat: directed scenarios plus randomized
// traffic against a field-level behavioural model.
module tb_ps_astat;

    localparam int DATASIZE = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                ps_shf_en = 0, shf_ps_sv = 0, shf_ps_sz = 0;
    logic                ps_alu_en = 0, alu_ps_az = 0, alu_ps_an = 0, alu_ps_av = 0, alu_ps_ac = 0;
    logic                ps_astat_we = 0;
    logic [DATASIZE-1:0] xb_dtx = '0;
    logic                ps_stky_clr = 0, ps_astat_sel = 0;
    logic [DATASIZE-1:0] astat_xb_dt;
    logic [3:0]          ps_cond = 4'd0;
    logic                astat_ps_cond_true;

    int checks = 0;
    int errors = 0;

    // Model state: architectural flags by name, plus pending issue strobes
    logic [5:0]  m_astat;
    logic [1:0]  m_stky;
    logic        m_shf_pend, m_alu_pend;
    logic [15:0] m_rd;

    always #5 clk = ~clk;

    ps_astat #(.DATASIZE(DATASIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .ps_shf_en(ps_shf_en), .shf_ps_sv(shf_ps_sv), .shf_ps_sz(shf_ps_sz),
        .ps_alu_en(ps_alu_en), .alu_ps_az(alu_ps_az), .alu_ps_an(alu_ps_an),
        .alu_ps_av(alu_ps_av), .alu_ps_ac(alu_ps_ac),
        .ps_astat_we(ps_astat_we), .xb_dtx(xb_dtx), .ps_stky_clr(ps_stky_clr),
        .ps_astat_sel(ps_astat_sel), .astat_xb_dt(astat_xb_dt),
        .ps_cond(ps_cond), .astat_ps_cond_true(astat_ps_cond_true)
    );

    function automatic logic model_cond(input logic [5:0] a, input logic [3:0] code);
        logic az, an, av, ac, sv, sz, r;
        {sz, sv, ac, av, an, az} = a;
        case (code % 8)
            0: r = az;
            1: r = an;
            2: r = an || az;
            3: r = ac;
            4: r = av;
            5: r = sv;
            6: r = sz;
            default: r = 1'b1;
        endcase
        return (code >= 8) ? !r : r;
    endfunction

    // Advance one clock, applying the architectural update rules to the model
    task automatic tick;
        logic [5:0]  na;
        logic [1:0]  ns;
        logic [15:0] rd;
        rd = ps_astat_sel ? {14'd0, m_stky} : {10'd0, m_astat};
        na = ps_astat_we ? xb_dtx[5:0] : m_astat;
        if (m_alu_pend) na[3:0] = {alu_ps_ac, alu_ps_av, alu_ps_an, alu_ps_az};
        if (m_shf_pend) na[5:4] = {shf_ps_sz, shf_ps_sv};
        ns = ps_stky_clr ? 2'b00 : m_stky;
        if (m_alu_pend && alu_ps_av) ns[0] = 1'b1;
        if (m_shf_pend && shf_ps_sv) ns[1] = 1'b1;
        @(posedge clk);
        m_astat    = na;
        m_stky     = ns;
        m_rd       = rd;
        m_shf_pend = ps_shf_en;
        m_alu_pend = ps_alu_en;
        #1;
    endtask

    task automatic idle_inputs;
        ps_shf_en = 0; shf_ps_sv = 0; shf_ps_sz = 0;
        ps_alu_en = 0; alu_ps_az = 0; alu_ps_an = 0; alu_ps_av = 0; alu_ps_ac = 0;
        ps_astat_we = 0; xb_dtx = '0; ps_stky_clr = 0; ps_astat_sel = 0;
    endtask

    task automatic model_reset;
        m_astat = '0; m_stky = '0; m_shf_pend = 0; m_alu_pend = 0; m_rd = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        #2 rst_n = 1'b0;
        model_reset();
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (astat_xb_dt !== 16'h0000) begin
            errors++; $display("FAIL reset_rd: got %h expected 0000", astat_xb_dt);
        end
        ps_cond = 4'd0; #1;
        checks++;
        if (astat_ps_cond_true !== 1'b0) begin
            errors++; $display("FAIL reset_cond_eq: got %b expected 0", astat_ps_cond_true);
        end
        ps_cond = 4'd8; #1;
        checks++;
        if (astat_ps_cond_true !== 1'b1) begin
            errors++; $display("FAIL reset_cond_ne: got %b expected 1", astat_ps_cond_true);
        end
        // Fill registers, then arm a shifter capture and reset between edges
        tick();
        ps_astat_we = 1; xb_dtx = 16'hFFFF; tick();
        ps_astat_we = 0; ps_shf_en = 1; ps_astat_sel = 0; tick();
        ps_shf_en = 0; shf_ps_sv = 1; shf_ps_sz = 1;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (astat_xb_dt !== 16'h0000) begin
            errors++; $display("FAIL async_reset_rd: got %h expected 0000", astat_xb_dt);
        end
        ps_cond = 4'd7; #1;
        checks++;
        if (astat_ps_cond_true !== 1'b1) begin
            errors++; $display("FAIL async_reset_true: got %b expected 1", astat_ps_cond_true);
        end
        ps_cond = 4'd3; #1;
        checks++;
        if (astat_ps_cond_true !== 1'b0) begin
            errors++; $display("FAIL async_reset_ac: got %b expected 0", astat_ps_cond_true);
        end
        rst_n = 1'b1;
        tick();
        shf_ps_sv = 0; shf_ps_sz = 0;
        ps_astat_sel = 0; tick();
        checks++;
        if (astat_xb_dt !== 16'h0000) begin
            errors++; $display("FAIL reset_no_capture_astat: got %h expected 0000", astat_xb_dt);
        end
        ps_astat_sel = 1; tick();
        checks++;
        if (astat_xb_dt !== 16'h0000) begin
            errors++; $display("FAIL reset_no_capture_stky: got %h expected 0000", astat_xb_dt);
        end
    endtask

    task automatic test_shf_capture;
        do_reset();
        ps_shf_en = 1; tick();
        ps_shf_en = 0; shf_ps_sv = 1; shf_ps_sz = 0; tick();
        shf_ps_sv = 0;
        ps_cond = 4'd5; #1;
        checks++;
        if (astat_ps_cond_true !== 1'b1) begin
            errors++; $display("FAIL shf_cond_sv: got %b expected 1", astat_ps_cond_true);
        end
        ps_cond = 4'd13; #1;
        checks++;
        if (astat_ps_cond_true !== 1'b0) begin
            errors++; $display("FAIL shf_cond_nsv: got %b expected 0", astat_ps_cond_true);
        end
        ps_astat_sel = 0; tick();
        checks++;
        if (astat_xb_dt !== 16'h0010) begin
            errors++; $display("FAIL shf_astat: got %h expected 0010", astat_xb_dt);
        end
        ps_astat_sel = 1; tick();
        checks++;
        if (astat_xb_dt !== 16'h0002) begin
            errors++; $display("FAIL shf_stky: got %h expected 0002", astat_xb_dt);
        end
    endtask

    task automatic test_no_enable;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            shf_ps_sv = i[0]; shf_ps_sz = ~i[0];
            alu_ps_av = 1; alu_ps_az = i[1];
            tick();
        end
        idle_inputs();
        ps_astat_sel = 0; tick();
        checks++;
        if (astat_xb_dt !== 16'h0000) begin
            errors++; $display("FAIL no_enable_astat: got %h expected 0000", astat_xb_dt);
        end
        ps_astat_sel = 1; tick();
        checks++;
        if (astat_xb_dt !== 16'h0000) begin
            errors++; $display("FAIL no_enable_stky: got %h expected 0000", astat_xb_dt);
        end
    endtask

    task automatic test_write_collision;
        do_reset();
        ps_shf_en = 1; tick();
        ps_shf_en = 0; shf_ps_sv = 0; shf_ps_sz = 1;
        ps_astat_we = 1; xb_dtx = 16'hFFFF; tick();
        idle_inputs();
        ps_astat_sel = 0; tick();
        checks++;
        if (astat_xb_dt !== 16'h002F) begin
            errors++; $display("FAIL collision_astat: got %h expected 002F", astat_xb_dt);
        end
        ps_astat_sel = 1; tick();
        checks++;
        if (astat_xb_dt !== 16'h0000) begin
            errors++; $display("FAIL collision_stky: got %h expected 0000", astat_xb_dt);
        end
    endtask

    task automatic test_sticky;
        do_reset();
        ps_shf_en = 1; tick();
        ps_shf_en = 0; shf_ps_sv = 1; ps_stky_clr = 1; tick();
        shf_ps_sv = 0; ps_stky_clr = 0; ps_astat_sel = 1; tick();
        checks++;
        if (astat_xb_dt !== 16'h0002) begin
            errors++; $display("FAIL sticky_set_wins: got %h expected 0002", astat_xb_dt);
        end
        ps_stky_clr = 1; tick();
        checks++;
        if (astat_xb_dt !== 16'h0002) begin
            errors++; $display("FAIL sticky_pre_edge_read: got %h expected 0002", astat_xb_dt);
        end
        ps_stky_clr = 0; tick();
        checks++;
        if (astat_xb_dt !== 16'h0000) begin
            errors++; $display("FAIL sticky_cleared: got %h expected 0000", astat_xb_dt);
        end
    endtask

    task automatic test_dual_capture;
        logic [3:0] codes [4];
        logic       exp   [4];
        codes = '{4'd0, 4'd6, 4'd15, 4'd7};
        exp   = '{1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        ps_shf_en = 1; ps_alu_en = 1; tick();
        ps_shf_en = 0; ps_alu_en = 0; alu_ps_az = 1; shf_ps_sz = 1; tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            ps_cond = codes[i]; #1;
            checks++;
            if (astat_ps_cond_true !== exp[i]) begin
                errors++;
                $display("FAIL dual_cond_%0d: got %b expected %b", codes[i], astat_ps_cond_true, exp[i]);
            end
        end
        ps_astat_sel = 0; tick();
        checks++;
        if (astat_xb_dt !== 16'h0021) begin
            errors++; $display("FAIL dual_astat: got %h expected 0021", astat_xb_dt);
        end
    endtask

    task automatic test_back_to_back_random;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ps_shf_en    = ($urandom_range(0, 3) != 0);
            ps_alu_en    = ($urandom_range(0, 3) != 0);
            shf_ps_sv    = $urandom_range(0, 1);
            shf_ps_sz    = $urandom_range(0, 1);
            alu_ps_az    = $urandom_range(0, 1);
            alu_ps_an    = $urandom_range(0, 1);
            alu_ps_av    = ($urandom_range(0, 4) == 0);
            alu_ps_ac    = $urandom_range(0, 1);
            ps_astat_we  = ($urandom_range(0, 5) == 0);
            xb_dtx       = DATASIZE'($urandom);
            ps_stky_clr  = ($urandom_range(0, 7) == 0);
            ps_astat_sel = $urandom_range(0, 1);
            tick();
            checks++;
            if (astat_xb_dt !== m_rd) begin
                errors++; $display("FAIL rand_rd[%0d]: got %h expected %h", i, astat_xb_dt, m_rd);
            end
            ps_cond = 4'($urandom_range(0, 15)); #1;
            checks++;
            if (astat_ps_cond_true !== model_cond(m_astat, ps_cond)) begin
                errors++;
                $display("FAIL rand_cond[%0d] code %0d: got %b expected %b",
                         i, ps_cond, astat_ps_cond_true, model_cond(m_astat, ps_cond));
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_shf_capture();
        test_no_enable();
        test_write_collision();
        test_sticky();
        test_dual_capture();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps_astat.md
Name: ps_astat

Overview:
- Arithmetic status and sticky-flag register in the program sequencer.
- Directly downstream of the shifter and ALU flag outputs: captures shifter flags (sv, sz) and ALU flags (az, an, av, ac) one cycle after the unit's enable.
- Keeps sticky overflow bits, supports explicit crossbar write and read.
- Evaluates the 4-bit condition code used by the sequencer for conditional issue.

Parameters:
- DATASIZE, 16, width of crossbar data and of the ASTAT/STKY registers.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ps_shf_en  input  1  shifter issue strobe, same cycle the shifter latches operands.
- shf_ps_sv  input  1  shifter overflow flag, valid the cycle after ps_shf_en.
- shf_ps_sz  input  1  shifter zero flag, valid the cycle after ps_shf_en.
- ps_alu_en  input  1  ALU issue strobe, same timing rule as ps_shf_en.
- alu_ps_az, alu_ps_an, alu_ps_av, alu_ps_ac  input  1 each  ALU zero/negative/overflow/carry, valid the cycle after ps_alu_en.
- ps_astat_we  input  1  explicit ASTAT write strobe.
- xb_dtx  input  DATASIZE  write data for ASTAT.
- ps_stky_clr  input  1  clear all STKY bits.
- ps_astat_sel  input  1  read select: 0 = ASTAT, 1 = STKY.
- astat_xb_dt  output  DATASIZE  registered read data.
- ps_cond  input  4  condition code select.
- astat_ps_cond_true  output  1  combinational condition result.

Behaviour:
- Reset:
  - Asynchronous on rst_n low. ASTAT = 0, STKY = 0, astat_xb_dt = 0, and both internal enable delays (shf_en_d, alu_en_d) = 0.
  - Reset mid-operation discards any pending flag capture.
- Register layout (all other bits read as 0 and are not writable):
  - ASTAT: bit0 AZ, bit1 AN, bit2 AV, bit3 AC, bit4 SV, bit5 SZ.
  - STKY: bit0 AVS, bit1 SVS.
- Pipeline:
  - shf_en_d <= ps_shf_en and alu_en_d <= ps_alu_en every cycle.
  - Enable in cycle N: flags are sampled at the end of cycle N+1 and visible in ASTAT from cycle N+2.
  - Back-to-back enables update ASTAT every cycle.
- Capture rules:
  - shf_en_d = 1: ASTAT[5:4] <= {shf_ps_sz, shf_ps_sv}.
  - alu_en_d = 1: ASTAT[3:0] <= {ac, av, an, az}.
  - Flag inputs are ignored when the matching delay bit is 0.
- Explicit write:
  - ps_astat_we = 1: ASTAT[5:0] <= xb_dtx[5:0], except fields being captured from a unit on the same edge. Unit capture wins per field; the remaining fields take the write data.
- Sticky bits:
  - STKY[0] sets when the ALU captures av = 1; STKY[1] sets when the shifter captures sv = 1.
  - An explicit ASTAT write does not set STKY.
  - ps_stky_clr clears both bits. Set and clear on the same edge: set wins for that bit.
- Read:
  - astat_xb_dt <= (ps_astat_sel ? STKY : ASTAT), zero-extended, one-cycle latency.
  - Returns the pre-edge value when an update occurs on the same edge.
- Conditions:
  - Evaluated from registered ASTAT only; no bypass of in-flight flags.
  - Codes: 0 EQ = AZ, 1 LT = AN, 2 LE = AN|AZ, 3 AC, 4 AV, 5 SV, 6 SZ, 7 TRUE.
  - Codes 8-15 are the inversions of 0-7 (8 NE, …, 15 FALSE).

Decomposition:
- Shared package holds:
  - ASTAT/STKY bit-index constants (AZ_BIT … SZ_BIT, AVS_BIT, SVS_BIT).
  - Condition-code localparams (COND_EQ … COND_FALSE).
  - The ASTAT valid-bit mask 16'h003F and the STKY mask 16'h0003.
- One sub-module: ps_cond_eval, purely combinational (ASTAT[5:0], ps_cond) -> astat_ps_cond_true.

Test Plan:
- Async reset: drive rst_n low between clock edges while shf_en_d = 1 -> ASTAT, STKY and astat_xb_dt become 0x0000 immediately, and no capture follows release.
- Shifter capture: ps_shf_en = 1 in cycle N; in N+1 drive sv = 1, sz = 0 -> ASTAT = 0x0010 and STKY = 0x0002 from N+2; ps_cond = 5 gives 1, ps_cond = 13 gives 0.
- No enable: toggle shf_ps_sv and shf_ps_sz with ps_shf_en low in the prior cycle -> ASTAT unchanged at 0x0000.
- Write/capture collision: ps_astat_we with xb_dtx = 0xFFFF on the same edge as shifter capture sv = 0, sz = 1 -> ASTAT = 0x002F and STKY unchanged.
- Sticky collision: ps_stky_clr on the same edge as capture sv = 1 -> STKY[1] = 1; a following clear without a set -> STKY = 0x0000. Reading with ps_astat_sel = 1 returns each value one cycle later.
- Dual capture: ALU az = 1 and shifter sz = 1 on the same edge -> ASTAT = 0x0021; conds 0 and 6 give 1, cond 15 gives 0, cond 7 gives 1.
